ex_alu_unit: RTL and testbench
==============================

Name: ex_alu_unit

Overview:
EX-stage execution unit of the pipelined MIPS core. It sits directly downstream of the ALU control decoder and consumes its 4-bit ALUctl together with the forwarded operands.
- Single-cycle ops: computed combinationally.
- mult: a 32-iteration shift-add sequencer that stalls the front of the pipeline until the product is ready, keeping the upper half in a HI register.

Parameters:
WIDTH, 32, operand/result width; the multiplier runs WIDTH iterations and HI is WIDTH bits

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX slot holds a real (non-bubble) instruction
flush  in  1  squash the EX instruction (branch/exception); aborts any multiply
ALUctl  in  4  operation select from ALU control
src_a  in  WIDTH  operand A (rs, post-forwarding)
src_b  in  WIDTH  operand B (rt or sign-extended immediate)
alu_result  out  WIDTH  result to EX/MEM
zero  out  1  alu_result == 0
stall  out  1  hold PC, IF/ID, ID/EX; insert bubble into EX/MEM
hi  out  WIDTH  upper half of the last completed mult product
overflow  out  1  signed add/sub overflow (tied 0 without ALU_OVF_EN)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, counter=0, hi=0, product/operand registers=0.
  - stall forced 0 while rst_n is low.
  - overflow=0.
  - alu_result and zero follow inputs per the IDLE rules below.
- ALUctl decode (IDLE state), results combinational, zero latency:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0011 SUB (beq compare / nop)
  - 0111 SLT signed (1 or 0)
  - 1100 NOR
  - 1111 XOR
  - any other code: result 0
  - All arithmetic is modulo 2^WIDTH.
  - 1000 (mult) in IDLE: alu_result=0.
- FSM states: IDLE, MUL_RUN, MUL_DONE.
- IDLE -> MUL_RUN: when ex_valid=1, flush=0 and ALUctl=1000.
  - stall=1 combinationally in that same cycle.
  - On the edge: latch |src_a|, |src_b| and sign = src_a[MSB]^src_b[MSB]; clear the 2*WIDTH accumulator; counter=0.
- MUL_RUN:
  - stall=1.
  - Each cycle: if multiplier bit0 is set, add the multiplicand into the accumulator upper half; then shift right one bit.
  - counter increments each cycle; after the counter=WIDTH-1 cycle -> MUL_DONE.
  - On that final edge, apply two's-complement negation of the full 2*WIDTH product if sign=1.
- MUL_DONE (one cycle):
  - stall=0; alu_result=product[WIDTH-1:0]; zero per that value.
  - hi loads product[2*WIDTH-1:WIDTH] on the exiting edge.
  - Next state is always IDLE. The consumed mult is not re-triggered, because the pipeline advances on this edge.
- Latency for WIDTH=32: stall high for 33 consecutive cycles (detect cycle + 32 RUN cycles); the result is presented in the 34th cycle.
- flush in MUL_RUN or MUL_DONE: next state IDLE, stall=0 from the next cycle, hi unchanged, product discarded.
- flush in IDLE: no multiply starts.
- ex_valid=0: no multiply starts; single-cycle ops still evaluate (harmless bubble).
- Asynchronous reset mid-multiply: immediate return to IDLE, stall=0, hi=0.
- Operands and ALUctl may change during MUL_RUN (the pipeline is held) without effect; only the latched values are used.
- Most-negative operand (0x80000000): magnitude is 0x80000000 treated as unsigned; the product stays correct.

Optional Feature:
ALU_OVF_EN: when defined, overflow is driven as follows:
- ADD (0010): asserted when both operands have equal sign and the result sign differs.
- SUB (0110): asserted when operand signs differ and the result sign differs from src_a.
- Never asserted for 0011, logic ops, SLT or mult.
- Asserted only when ex_valid=1 and flush=0.
Without the macro, overflow is constant 0 and no detection logic is built.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001 with ALUctl=0010 -> alu_result=0x80000000, zero=0, stall=0; overflow=1 only with ALU_OVF_EN.
- ALUctl=0011, src_a=src_b=0x1234 -> alu_result=0, zero=1; then src_b=0x1235 -> alu_result=0xFFFFFFFF, zero=0.
- SLT 0xFFFFFFFE vs 0x00000001 -> 1; SLT 0x00000001 vs 0xFFFFFFFE -> 0; NOR 0,0 -> 0xFFFFFFFF; XOR 0xF0F0,0x0FF0 -> 0xFF00.
- mult src_a=-3 (0xFFFFFFFD), src_b=7, ex_valid=1 -> stall high exactly 33 cycles; in cycle 34 alu_result=0xFFFFFFEB, then hi=0xFFFFFFFF; a second mult 0x80000000 * 0x80000000 -> lo=0, hi=0x40000000.
- mult started, flush pulsed at RUN cycle 10 -> stall=0 next cycle, hi keeps its previous value, a following ADD completes in one cycle.
- mult started, rst_n pulsed low at RUN cycle 20 -> stall drops asynchronously, hi=0, state IDLE; a fresh mult 5*6 afterwards -> alu_result=30, hi=0.

Source files
------------

// File: rtl/ex_alu_unit.sv
// ex_alu_unit: EX-stage execution unit of the pipelined MIPS core.
//   Single-cycle ALU ops are combinational. A signed multiply runs as a
//   WIDTH-iteration shift-add sequence on operand magnitudes and holds the
//   front of the pipeline via stall. The upper half of the product lands in hi.
//
// Ports:
//   clk        pipeline clock, rising edge
//   rst_n      asynchronous active-low reset
//   ex_valid   EX slot holds a real instruction
//   flush      squash the EX instruction; aborts any multiply
//   ALUctl     operation select from ALU control
//   src_a      operand A (rs, post-forwarding)
//   src_b      operand B (rt or sign-extended immediate)
//   alu_result result to EX/MEM
//   zero       alu_result == 0
//   stall      hold PC, IF/ID, ID/EX; bubble into EX/MEM
//   hi         upper half of the last completed mult product
//   overflow   signed add/sub overflow
//
// Build option: define ALU_OVF_EN to build overflow detection; without it
// overflow is tied to 0.
//
// state    | meaning
// IDLE     | single-cycle ops; a valid, unflushed mult starts the sequencer
// MUL_RUN  | one shift-add iteration per cycle, pipeline stalled
// MUL_DONE | low product half on alu_result; hi loads on the exiting edge

module ex_alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             flush,
  input  logic [3:0]       ALUctl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic               sign;

  logic               start;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   add_res, sub_res, op_res;

  assign start = (state == IDLE) && ex_valid && !flush && (ALUctl == 4'b1000);
  assign abs_a = src_a[WIDTH-1] ? -src_a : src_a;
  assign abs_b = src_b[WIDTH-1] ? -src_b : src_b;

  // The multiplier occupies the low half of the accumulator and is consumed
  // bit by bit as partial sums shift in from the top, so the cleared
  // accumulator and the latched |src_b| share one register.
  assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : '0)};
  assign acc_step = {sum, acc[WIDTH-1:1]};

  assign add_res = src_a + src_b;
  assign sub_res = src_a - src_b;

  always_comb begin
    op_res = '0;
    case (ALUctl)
      4'b0000: op_res = src_a & src_b;
      4'b0001: op_res = src_a | src_b;
      4'b0010: op_res = add_res;
      4'b0110: op_res = sub_res;
      4'b0011: op_res = sub_res;
      4'b0111: op_res = ($signed(src_a) < $signed(src_b)) ? WIDTH'(1) : '0;
      4'b1100: op_res = ~(src_a | src_b);
      4'b1111: op_res = src_a ^ src_b;
      default: op_res = '0;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (state)
      IDLE:     alu_result = op_res;
      MUL_DONE: alu_result = acc[WIDTH-1:0];
      default:  alu_result = '0;
    endcase
  end

  assign zero  = (alu_result == '0);
  // Gated by rst_n so a pending mult request cannot stall while in reset.
  assign stall = rst_n && (start || (state == MUL_RUN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
      sign  <= 1'b0;
      hi    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= MUL_RUN;
            mcand <= abs_a;
            acc   <= {{WIDTH{1'b0}}, abs_b};
            sign  <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
            cnt   <= '0;
          end
        end
        MUL_RUN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == CNT_LAST) begin
              acc   <= sign ? -acc_step : acc_step;
              state <= MUL_DONE;
            end else begin
              acc <= acc_step;
            end
          end
        end
        MUL_DONE: begin
          state <= IDLE;
          if (!flush) hi <= acc[2*WIDTH-1:WIDTH];
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_OVF_EN
  logic ovf;
  always_comb begin
    ovf = 1'b0;
    if (state == IDLE && ex_valid && !flush) begin
      case (ALUctl)
        4'b0010: ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                       (add_res[WIDTH-1] != src_a[WIDTH-1]);
        4'b0110: ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                       (sub_res[WIDTH-1] != src_a[WIDTH-1]);
        default: ovf = 1'b0;
      endcase
    end
  end
  assign overflow = ovf;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ex_alu_unit.sv
module tb_ex_alu_unit;

  localparam bit OVF_ON =
`ifdef ALU_OVF_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, flush;
  logic [3:0]  ALUctl;
  logic [31:0] src_a, src_b;
  logic [31:0] alu_result, hi;
  logic        zero, stall, overflow;

  int checks = 0;
  int failures = 0;

  // expectations consumed by the per-cycle compare process
  logic [31:0] exp_res = '0;
  logic [31:0] exp_hi = '0;
  logic        exp_stall = 1'b0;
  logic        exp_ovf = 1'b0;
  logic        res_chk = 1'b1;

  always #5 clk = ~clk;

  ex_alu_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .flush(flush),
    .ALUctl(ALUctl), .src_a(src_a), .src_b(src_b),
    .alu_result(alu_result), .zero(zero), .stall(stall), .hi(hi),
    .overflow(overflow)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (ctl)
      4'd0:        return a & b;
      4'd1:        return a | b;
      4'd2:        return 32'(sa + sb);
      4'd3, 4'd6:  return 32'(sa - sb);
      4'd7:        return (sa < sb) ? 32'd1 : 32'd0;
      4'd12:       return ~(a | b);
      4'd15:       return a ^ b;
      default:     return 32'd0;
    endcase
  endfunction

  function automatic logic model_ovf(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                                     input logic v, input logic f);
    longint sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    if (!OVF_ON || !v || f) return 1'b0;
    if (ctl == 4'd2)      r = sa + sb;
    else if (ctl == 4'd6) r = sa - sb;
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  always @(negedge clk) begin
    chk("stall", stall, exp_stall);
    chk("hi", hi, exp_hi);
    chk("overflow", overflow, exp_ovf);
    if (res_chk) begin
      chk("result", alu_result, exp_res);
      chk("zero", zero, exp_res == 32'd0);
    end
  end

  // single-cycle op, entered at posedge+1, leaves at the next posedge+1
  task automatic op(input string nm, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                    input logic v, input logic f, input logic [31:0] lit);
    ALUctl = ctl; src_a = a; src_b = b; ex_valid = v; flush = f;
    exp_res = model_res(ctl, a, b);
    exp_ovf = model_ovf(ctl, a, b, v, f);
    exp_stall = 1'b0;
    res_chk = 1'b1;
    @(negedge clk);
    chk(nm, alu_result, lit);
    @(posedge clk); #1;
  endtask

  task automatic mult(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input int flush_at, input int rst_at,
                      input logic [31:0] lit_lo, input logic [31:0] lit_hi);
    longint pa, pb, p;
    logic [63:0] pu;
    int n;
    pa = $signed(a);
    pb = $signed(b);
    p  = pa * pb;
    pu = p;
    n  = 0;
    ALUctl = 4'b1000; src_a = a; src_b = b; ex_valid = 1'b1; flush = 1'b0;
    exp_stall = 1'b1; exp_res = '0; exp_ovf = 1'b0; res_chk = 1'b1;
    @(negedge clk); n += int'(stall);
    @(posedge clk); #1;
    for (int k = 1; k <= 32; k++) begin
      ALUctl = 4'($urandom); src_a = $urandom; src_b = $urandom;
      ex_valid = 1'($urandom); flush = 1'b0;
      exp_stall = 1'b1; res_chk = 1'b0; exp_ovf = 1'b0;
      if (k == flush_at) begin
        flush = 1'b1;
        @(negedge clk); n += int'(stall);
        @(posedge clk); #1;
        chk({nm, "_flush_stall_cycles"}, n, flush_at + 1);
        op({nm, "_post_flush_add"}, 4'd2, 32'h10, 32'h20, 1'b1, 1'b0, 32'h30);
        chk({nm, "_flush_hi"}, hi, lit_hi);
        return;
      end
      if (k == rst_at) begin
        ALUctl = 4'd2; src_a = 32'd1; src_b = 32'd2; ex_valid = 1'b1;
        #1 rst_n = 1'b0;
        exp_stall = 1'b0; exp_hi = '0; exp_res = 32'd3; res_chk = 1'b1;
        exp_ovf = model_ovf(4'd2, 32'd1, 32'd2, 1'b1, 1'b0);
        #1 chk({nm, "_rst_stall_async"}, stall, 1'b0);
        chk({nm, "_rst_hi"}, hi, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      @(negedge clk); n += int'(stall);
      @(posedge clk); #1;
    end
    // MUL_DONE cycle
    ALUctl = 4'($urandom); src_a = $urandom; src_b = $urandom; ex_valid = 1'($urandom); flush = 1'b0;
    exp_stall = 1'b0; exp_res = pu[31:0]; res_chk = 1'b1; exp_ovf = 1'b0;
    @(negedge clk); n += int'(stall);
    chk({nm, "_lo"}, alu_result, lit_lo);
    chk({nm, "_stall_cycles"}, n, 33);
    @(posedge clk); #1;
    ALUctl = 4'd0; ex_valid = 1'b0;
    exp_hi = pu[63:32];
    chk({nm, "_hi"}, hi, lit_hi);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ex_valid = 1'b1; flush = 1'b0; ALUctl = 4'b1000;
    src_a = 32'd3; src_b = 32'd4;
    exp_res = 32'd0; exp_stall = 1'b0; exp_hi = '0; exp_ovf = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_stall", stall, 1'b0);
    chk("reset_hi", hi, 32'd0);
    ALUctl = 4'd0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    op("add_max", 4'd2, 32'h7FFFFFFF, 32'h1, 1'b1, 1'b0, 32'h80000000);
    op("beq_eq", 4'd3, 32'h1234, 32'h1234, 1'b1, 1'b0, 32'h0);
    op("beq_ne", 4'd3, 32'h1234, 32'h1235, 1'b1, 1'b0, 32'hFFFFFFFF);
    op("slt_neg", 4'd7, 32'hFFFFFFFE, 32'h1, 1'b1, 1'b0, 32'h1);
    op("slt_pos", 4'd7, 32'h1, 32'hFFFFFFFE, 1'b1, 1'b0, 32'h0);
    op("nor_zero", 4'd12, 32'h0, 32'h0, 1'b1, 1'b0, 32'hFFFFFFFF);
    op("xor", 4'd15, 32'hF0F0, 32'h0FF0, 1'b1, 1'b0, 32'hFF00);
    op("and", 4'd0, 32'hFF00FF00, 32'h0F0F0F0F, 1'b1, 1'b0, 32'h0F000F00);
    op("or", 4'd1, 32'hFF000000, 32'h000000FF, 1'b1, 1'b0, 32'hFF0000FF);
    op("sub_min", 4'd6, 32'h80000000, 32'h1, 1'b1, 1'b0, 32'h7FFFFFFF);
    op("sub_plain", 4'd6, 32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFFFFFE);
    op("undef", 4'd5, 32'h1234, 32'h5678, 1'b1, 1'b0, 32'h0);
    op("mult_flushed", 4'd8, 32'd9, 32'd9, 1'b1, 1'b1, 32'h0);
    op("mult_bubble", 4'd8, 32'd9, 32'd9, 1'b0, 1'b0, 32'h0);
    op("add_bubble", 4'd2, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000);

    mult("mul_neg3x7", 32'hFFFFFFFD, 32'd7, 0, 0, 32'hFFFFFFEB, 32'hFFFFFFFF);
    mult("mul_min", 32'h80000000, 32'h80000000, 0, 0, 32'h0, 32'h40000000);
    mult("mul_flush", 32'd123, 32'd456, 10, 0, 32'h0, 32'h40000000);
    mult("mul_rst", 32'd11, 32'd13, 0, 20, 32'h0, 32'h0);
    mult("mul_5x6", 32'd5, 32'd6, 0, 0, 32'd30, 32'h0);
    op("final_add", 4'd2, 32'd100, 32'd23, 1'b1, 1'b0, 32'd123);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
